ps2_host_tx: RTL and testbench

PS2_HOST_TX -- requirements
Module: ps2_host_tx

---
 rtl/ps2_pkg.sv | 23 ++
 rtl/ps2_line_filter.sv | 38 +++
 rtl/ps2_host_tx.sv | 149 ++++++++++++++
 tb/tb_ps2_host_tx.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit state encoding, default timing constants
// and the odd-parity helper.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_REQ,
        ST_SHIFT,
        ST_PARITY,
        ST_STOP,
        ST_ACK,
        ST_RELEASE
    } ps2_state_e;

    localparam int PS2_INHIBIT_CYCLES = 4000;    // >= 100 us at 40 MHz
    localparam int PS2_TIMEOUT_CYCLES = 600000;  // ~15 ms at 40 MHz

    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// One PS/2 line: 2-FF synchronizer, then accept a level change only after
// FILTER_LEN consecutive samples disagree with the current output.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic din_i,
    output logic dout_o
);

    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q;
    logic          out_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= 2'b11;
            cnt_q  <= '0;
            out_q  <= 1'b1;
        end else begin
            sync_q <= {sync_q[0], din_i};
            if (sync_q[1] == out_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(FILTER_LEN - 1)) begin
                out_q <= sync_q[1];
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign dout_o = out_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, clock out
// 8 data bits + odd parity on device clock falls, check the device ACK.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = PS2_INHIBIT_CYCLES,
    parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES,
    parameter int FILTER_LEN     = 8
) (
    input  logic       CLK,
    input  logic       nRESET,
    input  logic [7:0] DATA_IN,
    input  logic       SEND,
    input  logic       PS2_CLK_IN,
    input  logic       PS2_DATA_IN,
    output logic       PS2_CLK_OE,
    output logic       PS2_DATA_OE,
    output logic       BUSY,
    output logic       DONE,
    output logic       ERROR
);

    localparam int CMAX  = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W = $clog2(CMAX + 1);

    logic clk_f, data_f, clk_f_q, fall;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
        .clk_i(CLK), .rst_ni(nRESET), .din_i(PS2_CLK_IN), .dout_o(clk_f)
    );
    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
        .clk_i(CLK), .rst_ni(nRESET), .din_i(PS2_DATA_IN), .dout_o(data_f)
    );

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) clk_f_q <= 1'b1;
        else         clk_f_q <= clk_f;
    end

    assign fall = clk_f_q & ~clk_f;

    ps2_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bit_q;
    logic [7:0]       sh_q;
    logic             par_q, ack_q;
    logic             clk_oe_q, data_oe_q, busy_q, done_q, err_q;

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            sh_q      <= '0;
            par_q     <= 1'b0;
            ack_q     <= 1'b0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    clk_oe_q  <= 1'b0;
                    data_oe_q <= 1'b0;
                    busy_q    <= 1'b0;
                    if (SEND) begin
                        sh_q     <= DATA_IN;
                        par_q    <= odd_parity(DATA_IN);
                        err_q    <= 1'b0;
                        ack_q    <= 1'b0;
                        cnt_q    <= '0;
                        clk_oe_q <= 1'b1;
                        busy_q   <= 1'b1;
                        state_q  <= ST_INHIBIT;
                    end
                end
                ST_INHIBIT: begin
                    cnt_q <= cnt_q + 1'b1;
                    // start bit goes low one cycle before the clock is released
                    if (cnt_q == CNT_W'(INHIBIT_CYCLES - 2)) data_oe_q <= 1'b1;
                    if (cnt_q == CNT_W'(INHIBIT_CYCLES - 1)) begin
                        cnt_q     <= '0;
                        clk_oe_q  <= 1'b0;
                        data_oe_q <= 1'b1;
                        state_q   <= ST_REQ;
                    end
                end
                ST_REQ, ST_SHIFT, ST_PARITY, ST_STOP, ST_ACK: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        clk_oe_q  <= 1'b0;
                        data_oe_q <= 1'b0;
                        err_q     <= 1'b1;
                        done_q    <= 1'b1;
                        state_q   <= ST_RELEASE;
                    end else begin
                        case (state_q)
                            ST_REQ: if (fall) begin
                                bit_q     <= '0;
                                data_oe_q <= ~sh_q[0];
                                state_q   <= ST_SHIFT;
                            end
                            ST_SHIFT: if (fall) begin
                                if (bit_q == 3'd7) begin
                                    data_oe_q <= ~par_q;
                                    state_q   <= ST_PARITY;
                                end else begin
                                    bit_q     <= bit_q + 3'd1;
                                    data_oe_q <= ~sh_q[bit_q + 3'd1];
                                end
                            end
                            ST_PARITY: if (fall) begin
                                data_oe_q <= 1'b0;
                                state_q   <= ST_STOP;
                            end
                            ST_STOP: if (fall) begin
                                ack_q   <= ~data_f;
                                state_q <= ST_ACK;
                            end
                            ST_ACK: if (clk_f && data_f) begin
                                done_q  <= 1'b1;
                                err_q   <= ~ack_q;
                                state_q <= ST_RELEASE;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_RELEASE: begin
                    clk_oe_q  <= 1'b0;
                    data_oe_q <= 1'b0;
                    busy_q    <= 1'b0;
                    state_q   <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign PS2_CLK_OE  = clk_oe_q;
    assign PS2_DATA_OE = data_oe_q;
    assign BUSY        = busy_q;
    assign DONE        = done_q;
    assign ERROR       = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboarded bench for ps2_host_tx with an open-drain bus and a PS/2 device model.
module tb_ps2_host_tx;

    localparam int INH  = 40;
    localparam int TO   = 3000;
    localparam int FL   = 4;
    localparam int HALF = 20;

    logic       CLK = 1'b0;
    logic       nRESET = 1'b0;
    logic [7:0] DATA_IN = 8'h00;
    logic       SEND = 1'b0;
    logic       dev_clk_low = 1'b0, dev_data_low = 1'b0, glitch = 1'b0;
    logic       clk_oe, data_oe, busy, done, error;
    logic       clk_line, data_line, clk_pin;

    assign clk_line  = ~(clk_oe | dev_clk_low);
    assign data_line = ~(data_oe | dev_data_low);
    assign clk_pin   = clk_line & ~glitch;

    always #5 CLK = ~CLK;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO), .FILTER_LEN(FL)) dut (
        .CLK(CLK), .nRESET(nRESET), .DATA_IN(DATA_IN), .SEND(SEND),
        .PS2_CLK_IN(clk_pin), .PS2_DATA_IN(data_line),
        .PS2_CLK_OE(clk_oe), .PS2_DATA_OE(data_oe),
        .BUSY(busy), .DONE(done), .ERROR(error)
    );

    typedef struct {
        logic [7:0] b;
        logic       err;
        logic       chk;
    } exp_t;

    exp_t       sbq[$];
    int         n_vec = 0, n_bad = 0, n_done = 0;
    logic [9:0] cap = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // line-level frame the device should see: 8 data bits, odd parity, stop=1
    function automatic logic [9:0] ref_frame(input logic [7:0] b);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, b};
    endfunction

    initial begin
        forever begin
            @(negedge CLK);
            if (done === 1'b1) begin
                n_done++;
                if (sbq.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    check("done_busy", 32'(busy), 32'd1);
                    check("error", 32'(error), 32'(e.err));
                    check("clk_oe_released", 32'(clk_oe), 32'd0);
                    check("data_oe_released", 32'(data_oe), 32'd0);
                    if (e.chk) check("frame_bits", 32'(cap), 32'(ref_frame(e.b)));
                    @(negedge CLK);
                    check("done_one_cycle", 32'(done), 32'd0);
                    check("idle_busy", 32'(busy), 32'd0);
                end
            end
        end
    end

    task automatic device(input bit ack, input bit glitch_en, input int abort_at);
        int t = 0;
        while (!(clk_oe === 1'b0 && data_oe === 1'b1) && t < INH + 100) begin
            @(negedge CLK);
            t++;
        end
        check("req_seen", 32'(t < INH + 100), 32'd1);
        check("start_bit", 32'(data_line), 32'd0);
        repeat (HALF) @(negedge CLK);
        for (int i = 0; i < 11; i++) begin
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge CLK);
            dev_clk_low = 1'b0;
            repeat (HALF / 2) @(negedge CLK);
            if (i < 10) cap[i] = data_line;
            if (glitch_en && i == 4) begin
                glitch = 1'b1;
                @(negedge CLK);
                glitch = 1'b0;
            end
            if (i == abort_at) return;
            if (i == 9 && ack) dev_data_low = 1'b1;
            repeat (HALF / 2) @(negedge CLK);
        end
        dev_data_low = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge CLK);
        DATA_IN = b;
        SEND    = 1'b1;
        @(negedge CLK);
        SEND    = 1'b0;
        check("send_latency_clk_oe", 32'(clk_oe), 32'd1);
        check("busy_after_send", 32'(busy), 32'd1);
        check("error_cleared", 32'(error), 32'd0);
    endtask

    task automatic wait_done(input int n0, input int bound);
        int t = 0;
        while (n_done == n0 && t < bound) begin
            @(negedge CLK);
            t++;
        end
        check("done_seen", 32'(n_done != n0), 32'd1);
        repeat (20) @(negedge CLK);
    endtask

    task automatic frame(input logic [7:0] b, input bit ack, input bit glitch_en, input bit second);
        exp_t e;
        int   n0 = n_done;
        e.b = b; e.err = ~ack; e.chk = 1'b1;
        sbq.push_back(e);
        send(b);
        fork
            device(ack, glitch_en, -1);
            if (second) begin
                repeat (150) @(negedge CLK);
                DATA_IN = ~b;
                SEND    = 1'b1;
                @(negedge CLK);
                SEND    = 1'b0;
            end
        join
        wait_done(n0, TO + 1000);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   n0;
        repeat (3) @(negedge CLK);
        check("rst_clk_oe", 32'(clk_oe), 32'd0);
        check("rst_data_oe", 32'(data_oe), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        nRESET = 1'b1;
        repeat (5) @(negedge CLK);

        frame(8'hED, 1'b1, 1'b0, 1'b0);
        frame(8'h00, 1'b1, 1'b0, 1'b0);
        frame(8'hFF, 1'b1, 1'b0, 1'b0);
        frame(8'h07, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 6; k++) frame(8'($urandom_range(255)), 1'b1, 1'b0, 1'b0);

        frame(8'h5A, 1'b0, 1'b0, 1'b0);
        check("error_held_noack", 32'(error), 32'd1);

        // device never clocks: watchdog must end the frame
        n0 = n_done;
        e.b = 8'hA5; e.err = 1'b1; e.chk = 1'b0;
        sbq.push_back(e);
        send(8'hA5);
        wait_done(n0, TO + INH + 500);
        check("error_held_timeout", 32'(error), 32'd1);

        frame(8'h96, 1'b1, 1'b0, 1'b1);
        frame(8'hC3, 1'b1, 1'b1, 1'b0);

        // reset while bit 4 (a zero, so data is being pulled) is on the line
        n0 = n_done;
        send(8'h2C);
        device(1'b1, 1'b0, 4);
        check("pre_reset_data_oe", 32'(data_oe), 32'd1);
        #2 nRESET = 1'b0;
        #1;
        check("reset_clk_oe", 32'(clk_oe), 32'd0);
        check("reset_data_oe", 32'(data_oe), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_error", 32'(error), 32'd0);
        repeat (3) @(negedge CLK);
        nRESET = 1'b1;
        repeat (100) @(negedge CLK);
        check("no_done_after_reset", 32'(n_done), 32'(n0));

        frame(8'hF4, 1'b1, 1'b0, 1'b0);
        check("scoreboard_empty", 32'(sbq.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
